int2fp_seq: RTL

Parametrised sequential integer-to-floating-point converter, the successor to the fixed 128-bit-to-single-precision converter. It accepts an unsigned (with separate sign) or two's-complement integer over a valid/ready handshake. It normalises the value iteratively with a leading-one search and produces a packed IEEE-754-style word with configurable exponent and mantissa widths. It sits between integer datapath producers and the float pipeline. Status flags report exact, rounded and overflowed results.

---
 rtl/int2fp_pkg.sv | 26 ++
 rtl/int2fp_round.sv | 75 +++++++
 rtl/int2fp_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/int2fp_pkg.sv
// Shared types and constants for the sequential integer-to-float converter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package int2fp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } state_e;

    // Normalisation skips this many leading zeros per cycle when it can.
    localparam int COARSE_STEP = 8;

    typedef struct packed {
        logic zero;
        logic inexact;
        logic overflow;
    } flags_t;

    function automatic int unsigned int2fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/int2fp_round.sv
// Purpose: guard/sticky extraction, rounding and packing of a normalised magnitude.
// Latency: combinational.
// Backpressure: none; the parent holds the inputs stable.
// Ports: sign_i, mag_i (leading one at MSB or all-zero), exp_i (unbiased exponent),
//        data_o {sign, biased exponent, fraction}, flags_o {zero, inexact, overflow}.
// Build option: INT2FP_ROUND_NEAREST_EN selects round-to-nearest-even, else truncation.
module int2fp_round
    import int2fp_pkg::*;
#(
    parameter int IN_W  = 128,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   sign_i,
    input  logic [IN_W-1:0]        mag_i,
    input  logic [EXP_W-1:0]       exp_i,
    output logic [EXP_W+MAN_W:0]   data_o,
    output flags_t                 flags_o
);

    localparam logic [EXP_W-1:0] BIAS  = EXP_W'(int2fp_bias(EXP_W));
    // Bits below the leading one, padded with MAN_W+1 zeros so the fraction
    // and guard always exist even when IN_W-1 < MAN_W.
    localparam int               EXT_W = IN_W + MAN_W;

    logic [EXT_W-1:0] ext;
    logic [MAN_W-1:0] frac;
    logic             guard;
    logic             sticky;
    logic             is_zero;
    logic [EXP_W-1:0] exp_b;
    logic [EXP_W-1:0] exp_r;
    logic [MAN_W-1:0] frac_r;
    logic             ovf;

    assign ext     = {mag_i[IN_W-2:0], {(MAN_W+1){1'b0}}};
    assign frac    = ext[EXT_W-1 -: MAN_W];
    assign guard   = ext[IN_W-1];
    assign sticky  = |ext[IN_W-2:0];
    assign is_zero = (mag_i == '0);
    // exp_i <= IN_W-1 <= BIAS, so this sum cannot reach all-ones by itself.
    assign exp_b   = exp_i + BIAS;

`ifdef INT2FP_ROUND_NEAREST_EN
    logic             inc;
    logic [MAN_W:0]   frac_sum;
    logic [EXP_W-1:0] exp_inc;

    assign inc      = guard & (sticky | frac[0]);
    assign frac_sum = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    // A fraction carry-out leaves the fraction at zero and bumps the exponent.
    assign exp_inc  = exp_b + {{(EXP_W-1){1'b0}}, frac_sum[MAN_W]};
    assign ovf      = (exp_inc == '1);
    assign exp_r    = exp_inc;
    assign frac_r   = ovf ? '0 : frac_sum[MAN_W-1:0];
`else
    assign ovf      = 1'b0;
    assign exp_r    = exp_b;
    assign frac_r   = frac;
`endif

    always_comb begin
        data_o           = {sign_i, exp_r, frac_r};
        flags_o.zero     = 1'b0;
        flags_o.inexact  = guard | sticky;
        flags_o.overflow = ovf;
        if (is_zero) begin
            data_o           = '0;
            flags_o.zero     = 1'b1;
            flags_o.inexact  = 1'b0;
            flags_o.overflow = 1'b0;
        end
    end

endmodule

// File: rtl/int2fp_seq.sv
// Purpose: iterative integer-to-float converter (sign+magnitude or two's complement in).
// Latency: 2 cycles for zero, else k+3 with k = lz/8 + lz%8, counting the accept cycle.
// Backpressure: one conversion in flight; in_ready low until output handshake, DONE stalls on out_ready.
// Ports: clk, reset (async active-low), in_valid/in_ready/in_data/in_mode/in_neg,
//        out_valid/out_ready/out_data/out_zero/out_inexact/out_overflow.
// Build option: INT2FP_ROUND_NEAREST_EN (rounding mode, handled in int2fp_round).
module int2fp_seq
    import int2fp_pkg::*;
#(
    parameter int IN_W  = 128,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_data,
    input  logic                 in_mode,
    input  logic                 in_neg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_data,
    output logic                 out_zero,
    output logic                 out_inexact,
    output logic                 out_overflow
);

    // Width of the coarse zero test; narrower inputs never take the coarse step.
    localparam int CW = (IN_W < COARSE_STEP) ? IN_W : COARSE_STEP;

    state_e                 state_q, state_d;
    logic [IN_W-1:0]        mag_q, mag_d;
    logic [EXP_W-1:0]       exp_q, exp_d;
    logic                   sign_q, sign_d;
    logic [EXP_W+MAN_W:0]   res_q, res_d;
    flags_t                 flg_q, flg_d;
    logic [EXP_W+MAN_W:0]   rnd_data;
    flags_t                 rnd_flags;

    int2fp_round #(
        .IN_W  (IN_W),
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign_i  (sign_q),
        .mag_i   (mag_q),
        .exp_i   (exp_q),
        .data_o  (rnd_data),
        .flags_o (rnd_flags)
    );

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        res_d   = res_q;
        flg_d   = flg_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_mode) begin
                        sign_d = in_data[IN_W-1];
                        // Negation mod 2^IN_W keeps the most negative value exact.
                        mag_d  = in_data[IN_W-1] ? ('0 - in_data) : in_data;
                    end else begin
                        sign_d = in_neg;
                        mag_d  = in_data;
                    end
                    exp_d   = EXP_W'(IN_W - 1);
                    state_d = (mag_d == '0) ? ST_ROUND : ST_NORM;
                end
            end
            ST_NORM: begin
                if (mag_q[IN_W-1 -: CW] == '0) begin
                    mag_d = mag_q << COARSE_STEP;
                    exp_d = exp_q - EXP_W'(COARSE_STEP);
                end else if (!mag_q[IN_W-1]) begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - EXP_W'(1);
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                res_d   = rnd_data;
                flg_d   = rnd_flags;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mag_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign out_data     = res_q;
    assign out_zero     = flg_q.zero;
    assign out_inexact  = flg_q.inexact;
    assign out_overflow = flg_q.overflow;

endmodule
